obi_ram_arbiter: RTL

Two-to-one OBI arbiter that shares one single-port memory slave (the testbench RAM model) between the core instruction-fetch port and the core data port. Arbitration is round-robin or fixed data-priority. An in-order ID FIFO of outstanding transactions steers each mem_rvalid_i back to the requester that issued it. It sits between the core OBI ports and the memory model in the core testbench.

---
 rtl/obi_ram_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/obi_ram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | obi_ram_arbiter: 2:1 OBI arbiter (instr/data) onto one memory port.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module obi_ram_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_PRIO       = 0
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     instr_req_i,
  output logic                                     instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                    instr_addr_i,
  output logic                                     instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]                    instr_rdata_o,
  output logic                                     instr_err_o,
  input  logic                                     data_req_i,
  output logic                                     data_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                    data_addr_i,
  input  logic                                     data_we_i,
  input  logic [DATA_WIDTH/8-1:0]                  data_be_i,
  input  logic [DATA_WIDTH-1:0]                    data_wdata_i,
  output logic                                     data_rvalid_o,
  output logic [DATA_WIDTH-1:0]                    data_rdata_o,
  output logic                                     data_err_o,
  output logic                                     mem_req_o,
  input  logic                                     mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]                    mem_addr_o,
  output logic                                     mem_we_o,
  output logic [DATA_WIDTH/8-1:0]                  mem_be_o,
  output logic [DATA_WIDTH-1:0]                    mem_wdata_o,
  input  logic                                     mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                    mem_rdata_i,
  input  logic                                     mem_err_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic                                     protocol_err_o
);

  localparam int   CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int   PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic SEL_INSTR = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       lock_valid_q, lock_sel_q, last_sel_q, protocol_err_q;
  logic                       full, sel, lock_hit, push, pop, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full = (count_q == CNT_W'(MAX_OUTSTANDING));
  // A held lock only counts while its owner still requests; a dropped request releases it.
  assign lock_hit = lock_valid_q && (lock_sel_q ? data_req_i : instr_req_i);

  always_comb begin
    sel = SEL_INSTR;
    if (lock_hit)                      sel = lock_sel_q;
    else if (data_req_i && !instr_req_i) sel = SEL_DATA;
    else if (instr_req_i && !data_req_i) sel = SEL_INSTR;
    else if (instr_req_i && data_req_i)  sel = (DATA_PRIO != 0) ? SEL_DATA : ~last_sel_q;
  end

  assign mem_req_o   = rst_ni && (instr_req_i || data_req_i) && !full;
  assign mem_addr_o  = sel ? data_addr_i : instr_addr_i;
  assign mem_we_o    = sel && data_we_i;
  assign mem_be_o    = sel ? data_be_i : '1;
  assign mem_wdata_o = sel ? data_wdata_i : '0;

  assign push        = mem_req_o && mem_gnt_i;
  assign instr_gnt_o = push && (sel == SEL_INSTR);
  assign data_gnt_o  = push && (sel == SEL_DATA);

  assign pop            = mem_rvalid_i && (count_q != '0);
  assign head           = id_q[rd_ptr_q];
  assign instr_rvalid_o = pop && (head == SEL_INSTR);
  assign data_rvalid_o  = pop && (head == SEL_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q           <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      lock_valid_q   <= 1'b0;
      lock_sel_q     <= SEL_INSTR;
      last_sel_q     <= SEL_INSTR;
      protocol_err_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      lock_valid_q <= mem_req_o && !mem_gnt_i;
      if (mem_req_o && !mem_gnt_i) lock_sel_q <= sel;
      if (push) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
        last_sel_q     <= sel;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (mem_rvalid_i && (count_q == '0)) protocol_err_q <= 1'b1;
    end
  end

  assign outstanding_o  = count_q;
  assign protocol_err_o = protocol_err_q;

endmodule
`default_nettype wire
